// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demultiplexer, one valid/ready holding register per channel.
// Optional per-channel saturating accept counters CNT0..CNT3 when DEMUX1TO4_CNT_EN is defined.

module demux1to4_chan #(
    parameter int K = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         wr_i,
    input  logic [K-1:0] data_i,
    input  logic         rdy_i,
    output logic [K-1:0] data_o,
    output logic         vld_o
`ifdef DEMUX1TO4_CNT_EN
    ,
    output logic [7:0]   cnt_o
`endif
);
    logic [K-1:0] data_q, data_d;
    logic         vld_q, vld_d;

    // A write in the same cycle as a drain wins, so a full channel streams at 1 word/cycle.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (wr_i) begin
            data_d = data_i;
            vld_d  = 1'b1;
        end else if (vld_q && rdy_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

`ifdef DEMUX1TO4_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_i && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`endif
endmodule

module demux1to4_reg #(
    parameter int K = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [K-1:0] I,
    input  logic [1:0]   SEL,
    input  logic         VALID_IN,
    output logic         READY_OUT,
    output logic [K-1:0] O0,
    output logic [K-1:0] O1,
    output logic [K-1:0] O2,
    output logic [K-1:0] O3,
    output logic         V0,
    output logic         V1,
    output logic         V2,
    output logic         V3,
    input  logic         R0,
    input  logic         R1,
    input  logic         R2,
    input  logic         R3
`ifdef DEMUX1TO4_CNT_EN
    ,
    output logic [7:0]   CNT0,
    output logic [7:0]   CNT1,
    output logic [7:0]   CNT2,
    output logic [7:0]   CNT3
`endif
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0][K-1:0] o_w;
    logic [NUM_CH-1:0]        v_w, r_w, wr_w;
    logic                     acc;
`ifdef DEMUX1TO4_CNT_EN
    logic [NUM_CH-1:0][7:0]   cnt_w;
`endif

    assign r_w = {R3, R2, R1, R0};

    // Ready looks only at the selected channel's state, never at I; held low during reset
    // so the producer never sees a handshake that the registers will not keep.
    assign READY_OUT = ~RST & (~v_w[SEL] | r_w[SEL]);
    assign acc       = VALID_IN & READY_OUT;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign wr_w[n] = acc & (SEL == n[1:0]);

        demux1to4_chan #(.K(K)) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .wr_i   (wr_w[n]),
            .data_i (I),
            .rdy_i  (r_w[n]),
            .data_o (o_w[n]),
            .vld_o  (v_w[n])
`ifdef DEMUX1TO4_CNT_EN
            ,
            .cnt_o  (cnt_w[n])
`endif
        );
    end

    assign O0 = o_w[0];
    assign O1 = o_w[1];
    assign O2 = o_w[2];
    assign O3 = o_w[3];
    assign V0 = v_w[0];
    assign V1 = v_w[1];
    assign V2 = v_w[2];
    assign V3 = v_w[3];
`ifdef DEMUX1TO4_CNT_EN
    assign CNT0 = cnt_w[0];
    assign CNT1 = cnt_w[1];
    assign CNT2 = cnt_w[2];
    assign CNT3 = cnt_w[3];
`endif
endmodule
